// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
package debounce_pkg;

  typedef enum logic {
    STABLE,
    VERIFY
  } state_e;

  // Counter wide enough to hold 0..stable_cycles; never narrower than one bit.
  function automatic int cnt_w(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, qualify-counter FSM, registered level and strobes.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 10,
  parameter int   SYNC_STAGES   = 2,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   out_nxt, rise_nxt, fall_nxt, flip;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flip      = 1'b0;
    unique case (state)
      STABLE: begin
        if (s != sw_out) begin
          if (STABLE_CYCLES == 1) begin
            flip = 1'b1;
          end else begin
            cnt_nxt   = CW'(1);
            state_nxt = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (s == sw_out) begin
          // Bounced back to the current level: drop the pending transition.
          cnt_nxt   = '0;
          state_nxt = STABLE;
        end else if (cnt == CNT_LAST) begin
          flip      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = STABLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = STABLE;
      end
    endcase
    out_nxt  = flip ? ~sw_out : sw_out;
    rise_nxt = flip & ~sw_out;
    fall_nxt = flip & sw_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STABLE;
      cnt    <= '0;
      sw_out <= INIT_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sw_out <= out_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debounce channels; top level is port slicing only.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   N_CH          = 4,
  parameter int   STABLE_CYCLES = 10,
  parameter int   SYNC_STAGES   = 2,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sw_in (sw_in[i]),
      .sw_out(sw_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel switch debouncer, the successor to the team's single-channel debounce FSM. Each of `N_CH` asynchronous switch inputs is synchronised, then filtered by a per-channel counter FSM. A channel's output changes only after its synchronised input has held the new level for `STABLE_CYCLES` consecutive clocks. Sits between board-level buttons/switches and control logic, and provides single-cycle rise/fall strobes so downstream blocks need no edge detectors.

## Interface
Clock `clk`; reset `rst`, synchronous and active-high. No other clock or reset.

Parameters:
- `N_CH`, 4: number of independent channels, ≥1
- `STABLE_CYCLES`, 10: consecutive differing cycles required before the output flips, ≥1
- `SYNC_STAGES`, 2: synchroniser depth, ≥2
- `INIT_LEVEL`, 1'b0: reset value of the synchroniser flops and of `sw_out`

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  synchronous active-high reset
- `sw_in`  in  N_CH  raw, asynchronous switch levels
- `sw_out`  out  N_CH  debounced levels, registered
- `rise`  out  N_CH  one-cycle pulse when `sw_out[i]` goes 0→1
- `fall`  out  N_CH  one-cycle pulse when `sw_out[i]` goes 1→0

## Operation
- Per channel: `SYNC_STAGES`-flop synchroniser producing `s[i]`, then FSM, counter `cnt` of width `$clog2(STABLE_CYCLES+1)`, and output register.
- FSM states:
  - STABLE: `cnt`=0. If `s != sw_out`, set `cnt`=1 and go to VERIFY. When `STABLE_CYCLES`=1, instead flip `sw_out` directly and stay in STABLE.
  - VERIFY:
    - If `s == sw_out` (bounce back): `cnt`=0, go to STABLE, no output change.
    - Else if `cnt == STABLE_CYCLES-1`: flip `sw_out`, `cnt`=0, go to STABLE.
    - Else `cnt`+1.
- `rise`/`fall` are registered and asserted in the same cycle that the new `sw_out` value is visible; they are deasserted otherwise. They are never both high on one channel.
- Channels are fully independent. Simultaneous activity on any subset of channels is handled with no interaction.
- Counter never exceeds `STABLE_CYCLES-1` and never wraps.
- Reset, at any time including mid-VERIFY: synchroniser flops and `sw_out` = `INIT_LEVEL`, `cnt`=0, state STABLE, `rise`=`fall`=0. The pending transition is discarded.
- After reset, an input that is already at `~INIT_LEVEL` is debounced normally. It produces a `rise` (or `fall`) after the full latency.

## Timing
- Input level change first sampled at edge 1. `s` shows the new level after edge `SYNC_STAGES`. `sw_out` and the strobe change at edge `SYNC_STAGES+STABLE_CYCLES` (12 with defaults).
- Any bounce back to the old level restarts qualification. The flip occurs `SYNC_STAGES+STABLE_CYCLES` edges after the last input transition.
- Strobe width is exactly one cycle. The minimum spacing between opposite strobes on one channel is `STABLE_CYCLES` cycles.
- Reset takes effect at the first rising edge with `rst`=1. All outputs read their reset values in the following cycle.

## Structure
- Shared package `debounce_pkg` contains:
  - the state enum {STABLE, VERIFY}
  - a counter-width function `cnt_w(stable_cycles)`
- Sub-module `debounce_ch` is one channel: synchroniser, FSM, counter, strobes. It takes `STABLE_CYCLES`, `SYNC_STAGES` and `INIT_LEVEL`.
- `debounce_multi` is a generate loop of `N_CH` instances of `debounce_ch` plus port slicing. There is no other logic.

## Test plan
- Defaults; `sw_in[0]` 0→1 at edge 1 and held → `sw_out[0]`=1 and `rise[0]`=1 at edge 12 only; `rise[0]` returns to 0 at edge 13; other channels stay 0.
- Glitch: `sw_in[1]` high for 5 cycles, then low → `sw_out[1]` stays 0, no strobes.
- Late bounce: `sw_in[2]` high, drops for 1 cycle at the 9th synchronised cycle, then high → flip occurs 12 edges after the final rising input, not earlier.
- All four channels toggle on the same edge with different hold times (10, 9, 20, 3 cycles) → only the channels held ≥10 flip, each strobing independently; then a release on one channel → `fall` pulse only on that channel.
- Reset asserted while channel 0 is in VERIFY with `cnt`=7 → next cycle `sw_out`=0, strobes 0. Input still high afterwards → `rise` occurs 12 edges after reset deasserts.
- `STABLE_CYCLES`=1, `INIT_LEVEL`=1: reset → `sw_out`=all ones. `sw_in[0]` drops → `fall[0]` at edge 3. A 1-cycle low pulse also propagates, documenting the minimum filter.
